// File: rtl/bmp_pkg.sv
// Shared definitions for the BMP grayscale converter: header byte offsets,
// luma coefficients, FSM state encoding and the row-padding helper.
// Optional header validation is compiled in with BMP_HDR_CHECK_EN.
package bmp_pkg;

  // Little-endian header field offsets (first byte of each field)
  localparam int HDR_OFS_SIG    = 0;
  localparam int HDR_OFS_PIX    = 10;
  localparam int HDR_OFS_WIDTH  = 18;
  localparam int HDR_OFS_HEIGHT = 22;
  localparam int HDR_OFS_BPP    = 28;
  localparam int HDR_BYTES      = 30;
  localparam int MIN_PIX_OFS    = 54;

  // Expected signature "BM" and pixel depth
  localparam logic [7:0]  SIG_B  = 8'h42;
  localparam logic [7:0]  SIG_M  = 8'h4D;
  localparam logic [15:0] BPP_24 = 16'd24;

  // Luma weights in 1/256 units; they sum to 256 so gray input maps to itself
  localparam logic [15:0] LUMA_R = 16'd77;
  localparam logic [15:0] LUMA_G = 16'd150;
  localparam logic [15:0] LUMA_B = 16'd29;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_HDR     = 4'd1,
    ST_PIX_B   = 4'd2,
    ST_PIX_G   = 4'd3,
    ST_PIX_R   = 4'd4,
    ST_CALC    = 4'd5,
    ST_WR_B    = 4'd6,
    ST_WR_G    = 4'd7,
    ST_WR_R    = 4'd8,
    ST_ROW_END = 4'd9,
`ifdef BMP_HDR_CHECK_EN
    ST_DONE    = 4'd10,
    ST_ERR     = 4'd11
`else
    ST_DONE    = 4'd10
`endif
  } state_t;

  // Padding bytes after a row of W pixels: (-(3*W)) mod 4, only W[1:0] matters
  function automatic logic [1:0] row_pad(input logic [1:0] w_lo);
    logic [1:0] used;
    used = w_lo * 2'd3;
    return 2'd0 - used;
  endfunction

endpackage

// File: rtl/bmp_gray_luma.sv
// Registered luma: Y = (77*R + 150*G + 29*B) >> 8 on a 16-bit unsigned sum.
// The weights sum to 256, so the sum never exceeds 65280 and Y never exceeds 255.
module bmp_gray_luma
  import bmp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [7:0] i_b,
  input  logic [7:0] i_g,
  input  logic [7:0] i_r,
  output logic [7:0] o_y
);

  logic [15:0] w_sum;
  logic [7:0]  r_y;

  assign w_sum = (LUMA_R * {8'd0, i_r}) + (LUMA_G * {8'd0, i_g}) + (LUMA_B * {8'd0, i_b});
  assign o_y   = r_y;

  // Capture the truncated luma when the converter is in its CALC cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y <= '0;
    end else if (i_en) begin
      r_y <= w_sum[15:8];
    end
  end

endmodule

// File: rtl/bmp_gray_convert.sv
// In-place 24-bpp BMP to grayscale converter on a single-port byte RAM.
// Reads the 30 header bytes, then for every pixel reads B,G,R, computes luma
// and writes it back to all three bytes; row padding and header are untouched.
// Define BMP_HDR_CHECK_EN to reject bad headers (signature, bpp, top-down
// height, pixel offset) into an ERR state with error=1.
//
// RAM handshake: RAM_ren and RAM_wen are mutually exclusive single-cycle
// strobes qualified by RAM_addr; read data appears on RAM_out the cycle after
// RAM_ren, and a write takes effect on the clock edge where RAM_wen is high.
module bmp_gray_convert
  import bmp_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int BYTE_WIDTH = 8,
  parameter int DIM_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  RAM_ren,
  output logic                  RAM_wen,
  output logic [ADDR_WIDTH-1:0] RAM_addr,
  output logic [BYTE_WIDTH-1:0] RAM_in,
  input  logic [BYTE_WIDTH-1:0] RAM_out,
  output logic                  done,
  output logic                  error,
  output logic [3:0]            dbg_state
);

`ifdef BMP_HDR_CHECK_EN
  localparam int OFS_BITS = 32;
`else
  localparam int OFS_BITS = ADDR_WIDTH;
`endif
  localparam logic [DIM_WIDTH-1:0]  DIM_ONE  = DIM_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_TWO = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] PIX_STEP = ADDR_WIDTH'(3);
  localparam logic [4:0]            HDR_LAST = 5'(HDR_BYTES);

  state_t                r_state;
  state_t                w_next;
  logic [4:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DIM_WIDTH-1:0]  r_col;
  logic [DIM_WIDTH-1:0]  r_row;
  logic [DIM_WIDTH-1:0]  r_width;
  logic [DIM_WIDTH-1:0]  r_height;
  logic [OFS_BITS-1:0]   r_pix_ofs;
  logic [BYTE_WIDTH-1:0] r_b;
  logic [BYTE_WIDTH-1:0] r_g;
`ifdef BMP_HDR_CHECK_EN
  logic [7:0]            r_sig0;
  logic [7:0]            r_sig1;
  logic [7:0]            r_bpp_lo;
  logic                  r_h_msb;
  logic                  w_hdr_bad;
`endif

  logic [4:0]            w_idx;
  logic                  w_cap;
  logic                  w_hdr_last;
  logic                  w_dim_zero;
  logic                  w_last_col;
  logic                  w_last_row;
  logic [1:0]            w_pad;
  logic [ADDR_WIDTH-1:0] w_pix_ofs;
  logic [7:0]            w_y;
  logic                  w_luma_en;
  logic                  w_ren;
  logic                  w_wen;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [BYTE_WIDTH-1:0] w_din;

  // Header byte k arrives while r_cnt == k+1 (one-cycle read latency)
  assign w_idx      = r_cnt - 5'd1;
  assign w_cap      = (r_state == ST_HDR) && (r_cnt != 5'd0);
  assign w_hdr_last = (r_cnt == HDR_LAST);
  assign w_dim_zero = (r_width == '0) || (r_height == '0);
  assign w_last_col = (r_col == (r_width - DIM_ONE));
  assign w_last_row = (r_row == (r_height - DIM_ONE));
  assign w_pad      = row_pad(r_width[1:0]);
  assign w_pix_ofs  = r_pix_ofs[ADDR_WIDTH-1:0];

`ifdef BMP_HDR_CHECK_EN
  // The upper bpp byte is still on RAM_out in the capture cycle
  assign w_hdr_bad = (r_sig0 != SIG_B) || (r_sig1 != SIG_M) ||
                     ({RAM_out, r_bpp_lo} != BPP_24) || r_h_msb ||
                     (r_pix_ofs < 32'(MIN_PIX_OFS));
  assign error     = (r_state == ST_ERR);
  assign done      = (r_state == ST_DONE) || (r_state == ST_ERR);
`else
  assign error     = 1'b0;
  assign done      = (r_state == ST_DONE);
`endif

  assign RAM_ren   = w_ren;
  assign RAM_wen   = w_wen;
  assign RAM_addr  = w_addr;
  assign RAM_in    = w_din;
  assign dbg_state = r_state;

  bmp_gray_luma u_luma (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_luma_en),
    .i_b  (r_b),
    .i_g  (r_g),
    .i_r  (RAM_out),
    .o_y  (w_y)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and RAM strobes; outputs are pure decodes of the current state
  always_comb begin
    w_next    = r_state;
    w_ren     = 1'b0;
    w_wen     = 1'b0;
    w_addr    = '0;
    w_din     = '0;
    w_luma_en = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_HDR;
      end
      ST_HDR: begin
        if (!w_hdr_last) begin
          w_ren  = 1'b1;
          w_addr = ADDR_WIDTH'(r_cnt);
        end else begin
`ifdef BMP_HDR_CHECK_EN
          if (w_hdr_bad)       w_next = ST_ERR;
          else if (w_dim_zero) w_next = ST_DONE;
          else                 w_next = ST_PIX_B;
`else
          if (w_dim_zero) w_next = ST_DONE;
          else            w_next = ST_PIX_B;
`endif
        end
      end
      ST_PIX_B: begin
        w_ren  = 1'b1;
        w_addr = r_addr;
        w_next = ST_PIX_G;
      end
      ST_PIX_G: begin
        w_ren  = 1'b1;
        w_addr = r_addr + ADDR_ONE;
        w_next = ST_PIX_R;
      end
      ST_PIX_R: begin
        w_ren  = 1'b1;
        w_addr = r_addr + ADDR_TWO;
        w_next = ST_CALC;
      end
      ST_CALC: begin
        w_luma_en = 1'b1;
        w_next    = ST_WR_B;
      end
      ST_WR_B: begin
        w_wen  = 1'b1;
        w_addr = r_addr;
        w_din  = BYTE_WIDTH'(w_y);
        w_next = ST_WR_G;
      end
      ST_WR_G: begin
        w_wen  = 1'b1;
        w_addr = r_addr + ADDR_ONE;
        w_din  = BYTE_WIDTH'(w_y);
        w_next = ST_WR_R;
      end
      ST_WR_R: begin
        w_wen  = 1'b1;
        w_addr = r_addr + ADDR_TWO;
        w_din  = BYTE_WIDTH'(w_y);
        w_next = w_last_col ? ST_ROW_END : ST_PIX_B;
      end
      ST_ROW_END: begin
        w_next = w_last_row ? ST_DONE : ST_PIX_B;
      end
      ST_DONE: begin
        if (start) w_next = ST_HDR;
      end
`ifdef BMP_HDR_CHECK_EN
      ST_ERR: begin
        if (start) w_next = ST_HDR;
      end
`endif
      default: w_next = ST_IDLE;
    endcase
  end

  // Walk counters, pixel address and the B/G holding registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_addr <= '0;
      r_col  <= '0;
      r_row  <= '0;
      r_b    <= '0;
      r_g    <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) r_cnt <= '0;
        end
`ifdef BMP_HDR_CHECK_EN
        ST_ERR: begin
          if (start) r_cnt <= '0;
        end
`endif
        ST_HDR: begin
          if (!w_hdr_last) begin
            r_cnt <= r_cnt + 5'd1;
          end else begin
            r_addr <= w_pix_ofs;
            r_col  <= '0;
            r_row  <= '0;
          end
        end
        ST_PIX_G: r_b <= RAM_out;
        ST_PIX_R: r_g <= RAM_out;
        ST_WR_R: begin
          r_addr <= r_addr + PIX_STEP;
          r_col  <= w_last_col ? '0 : (r_col + DIM_ONE);
        end
        ST_ROW_END: begin
          r_addr <= r_addr + ADDR_WIDTH'(w_pad);
          r_row  <= r_row + DIM_ONE;
        end
        default: ;
      endcase
    end
  end

  // Assemble little-endian header fields as their bytes stream in
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_width   <= '0;
      r_height  <= '0;
      r_pix_ofs <= '0;
`ifdef BMP_HDR_CHECK_EN
      r_sig0    <= '0;
      r_sig1    <= '0;
      r_bpp_lo  <= '0;
      r_h_msb   <= 1'b0;
`endif
    end else if (w_cap) begin
      for (int j = 0; j < OFS_BITS; j++) begin
        if (w_idx == 5'(HDR_OFS_PIX + j / 8)) r_pix_ofs[j] <= RAM_out[j % 8];
      end
      for (int j = 0; j < DIM_WIDTH; j++) begin
        if (w_idx == 5'(HDR_OFS_WIDTH + j / 8))  r_width[j]  <= RAM_out[j % 8];
        if (w_idx == 5'(HDR_OFS_HEIGHT + j / 8)) r_height[j] <= RAM_out[j % 8];
      end
`ifdef BMP_HDR_CHECK_EN
      if (w_idx == 5'(HDR_OFS_SIG))        r_sig0   <= RAM_out[7:0];
      if (w_idx == 5'(HDR_OFS_SIG + 1))    r_sig1   <= RAM_out[7:0];
      if (w_idx == 5'(HDR_OFS_BPP))        r_bpp_lo <= RAM_out[7:0];
      if (w_idx == 5'(HDR_OFS_HEIGHT + 3)) r_h_msb  <= RAM_out[7];
`endif
    end
  end

endmodule

// File: tb/tb_bmp_gray_convert.sv
// Bench for bmp_gray_convert: byte-RAM model, directed and random images,
// reference image computed from the BMP layout rules.
module tb_bmp_gray_convert;
  import bmp_pkg::*;

  localparam int MEM_SIZE = 1024;
  localparam int BUDGET   = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        RAM_ren;
  logic        RAM_wen;
  logic [19:0] RAM_addr;
  logic [7:0]  RAM_in;
  logic [7:0]  RAM_out = 8'd0;
  logic        done;
  logic        error;
  logic [3:0]  dbg_state;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0] mem     [MEM_SIZE];
  logic [7:0] img     [MEM_SIZE];
  logic [7:0] exp_img [MEM_SIZE];
  logic       do_load = 1'b0;
  int         wr_count = 0;
  int         both_count = 0;
  int         cur_w, cur_h, cur_ofs;

  // clock/reset
  always #5 clk = ~clk;

  bmp_gray_convert dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .RAM_ren   (RAM_ren),
    .RAM_wen   (RAM_wen),
    .RAM_addr  (RAM_addr),
    .RAM_in    (RAM_in),
    .RAM_out   (RAM_out),
    .done      (done),
    .error     (error),
    .dbg_state (dbg_state)
  );

  // Single-port RAM with 1-cycle read latency; do_load copies img into it
  always @(posedge clk) begin
    if (do_load) begin
      for (int i = 0; i < MEM_SIZE; i++) mem[i] = img[i];
      wr_count   = 0;
      both_count = 0;
    end else begin
      if (RAM_ren && RAM_wen) both_count++;
      if (RAM_wen) begin
        wr_count++;
        if (RAM_addr < 20'(MEM_SIZE)) mem[RAM_addr[9:0]] = RAM_in;
      end
      if (RAM_ren) RAM_out <= (RAM_addr < 20'(MEM_SIZE)) ? mem[RAM_addr[9:0]] : 8'd0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic int stride_of(input int w);
    return ((3 * w + 3) / 4) * 4;
  endfunction

  function automatic int latency_of(input int w, input int h);
    if (w == 0 || h == 0) return 31;
    return 31 + h * (7 * w + 1);
  endfunction

  // Random fill plus a header describing a w x h image at ofs
  task automatic prep_image(input int w, input int h, input int ofs, input int bpp);
    for (int i = 0; i < MEM_SIZE; i++) img[i] = 8'($urandom_range(0, 255));
    img[0] = 8'h42;
    img[1] = 8'h4D;
    for (int k = 0; k < 4; k++) begin
      img[10 + k] = 8'(ofs >> (8 * k));
      img[18 + k] = 8'(w >> (8 * k));
      img[22 + k] = 8'(h >> (8 * k));
    end
    img[28] = 8'(bpp);
    img[29] = 8'(bpp >> 8);
    cur_w = w; cur_h = h; cur_ofs = ofs;
  endtask

  task automatic set_px(input int r, input int c, input int b, input int g, input int rd);
    int a;
    a = cur_ofs + r * stride_of(cur_w) + 3 * c;
    img[a] = 8'(b); img[a + 1] = 8'(g); img[a + 2] = 8'(rd);
  endtask

  task automatic load_image();
    @(negedge clk); do_load = 1'b1;
    @(negedge clk); do_load = 1'b0;
  endtask

  // Reference: every pixel triple becomes its luma, everything else unchanged
  task automatic build_expected();
    int a, y;
    exp_img = img;
    for (int r = 0; r < cur_h; r++) begin
      for (int c = 0; c < cur_w; c++) begin
        a = cur_ofs + r * stride_of(cur_w) + 3 * c;
        y = (77 * int'(img[a + 2]) + 150 * int'(img[a + 1]) + 29 * int'(img[a])) / 256;
        exp_img[a] = 8'(y); exp_img[a + 1] = 8'(y); exp_img[a + 2] = 8'(y);
      end
    end
  endtask

  // driver: pulse start, count cycles to done, optional second start at mid_at
  task automatic run_conv(input string tag, input int exp_cycles, input int mid_at, input logic exp_err);
    int  cycles;
    bit  seen;
    cycles = 0; seen = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({tag, "_done_clear"}, 32'(done), 32'd0);
    while (!seen && cycles < BUDGET) begin
      @(posedge clk); cycles++;
      @(negedge clk);
      start = (cycles == mid_at);
      if (done) seen = 1;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 32'(cycles), 32'(exp_cycles));
    chk({tag, "_error"}, 32'(error), 32'(exp_err));
  endtask

  // scoreboard: whole-RAM compare against the reference image
  task automatic check_image(input string tag, input int exp_writes);
    int bad, first;
    bad = 0; first = -1;
    for (int i = 0; i < MEM_SIZE; i++) begin
      if (mem[i] !== exp_img[i]) begin
        if (bad == 0) first = i;
        bad++;
      end
    end
    if (bad != 0) $display("  %s first differing byte %0d: ram %0d model %0d", tag, first, mem[first], exp_img[first]);
    chk({tag, "_image"}, 32'(bad), 32'd0);
    if (exp_writes >= 0) chk({tag, "_writes"}, 32'(wr_count), 32'(exp_writes));
    chk({tag, "_rw_overlap"}, 32'(both_count), 32'd0);
  endtask

  initial begin
    int w, h, ofs, n_wr, cyc;
    rst = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ren", 32'(RAM_ren), 32'd0);
    chk("rst_wen", 32'(RAM_wen), 32'd0);
    chk("rst_addr", 32'(RAM_addr), 32'd0);
    chk("rst_din", 32'(RAM_in), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ren", 32'(RAM_ren), 32'd0);

    // 2x2 directed image
    prep_image(2, 2, 54, 24);
    set_px(0, 0, 0, 0, 255);
    set_px(0, 1, 0, 255, 0);
    set_px(1, 0, 255, 0, 0);
    set_px(1, 1, 255, 255, 255);
    load_image();
    build_expected();
    run_conv("img2x2", 61, 0, 1'b0);
    check_image("img2x2", 12);
    chk("img2x2_b54", 32'(mem[54]), 32'd76);
    chk("img2x2_b59", 32'(mem[59]), 32'd149);
    chk("img2x2_b62", 32'(mem[62]), 32'd28);
    chk("img2x2_b67", 32'(mem[67]), 32'd255);
    chk("img2x2_pad60", 32'(mem[60]), 32'(img[60]));
    chk("img2x2_pad69", 32'(mem[69]), 32'(img[69]));
    chk("img2x2_hdr53", 32'(mem[53]), 32'(img[53]));

    // restart from DONE on the converted image: unchanged result
    exp_img = mem;
    run_conv("rerun", 61, 0, 1'b0);
    check_image("rerun", -1);

    // 4x1, no padding, uniform pixels
    prep_image(4, 1, 54, 24);
    for (int c = 0; c < 4; c++) set_px(0, c, 10, 20, 30);
    load_image();
    build_expected();
    run_conv("img4x1", 60, 0, 1'b0);
    check_image("img4x1", 12);

    // random images
    for (int it = 0; it < 4; it++) begin
      w = $urandom_range(1, 7); h = $urandom_range(1, 4); ofs = $urandom_range(54, 64);
      prep_image(w, h, ofs, 24);
      load_image();
      build_expected();
      run_conv($sformatf("rand%0d", it), latency_of(w, h), 0, 1'b0);
      check_image($sformatf("rand%0d", it), 3 * w * h);
    end

    // degenerate dimensions
    prep_image(0, 3, 54, 24);
    load_image(); build_expected();
    run_conv("w0", 31, 0, 1'b0);
    check_image("w0", 0);
    prep_image(5, 0, 54, 24);
    load_image(); build_expected();
    run_conv("h0", 31, 0, 1'b0);
    check_image("h0", 0);

    // start while busy is ignored
    prep_image(3, 2, 56, 24);
    load_image(); build_expected();
    run_conv("busy_start", latency_of(3, 2), 40, 1'b0);
    check_image("busy_start", 18);

    // reset during pixel 1 WR_G, then a clean rerun
    prep_image(3, 2, 54, 24);
    load_image(); build_expected();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_wr = 0; cyc = 0;
    if (RAM_wen) n_wr++;
    while (n_wr < 5 && cyc < BUDGET) begin
      @(negedge clk); cyc++;
      if (RAM_wen) n_wr++;
    end
    chk("abort_at_wr_g", 32'(dbg_state), 32'(ST_WR_G));
    rst = 1'b1;
    #1;
    chk("abort_wen", 32'(RAM_wen), 32'd0);
    chk("abort_ren", 32'(RAM_ren), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk); rst = 1'b0;
    chk("abort_writes", 32'(wr_count), 32'd4);
    @(negedge clk);
    chk("abort_idle", 32'(dbg_state), 32'(ST_IDLE));
    load_image();
    run_conv("after_abort", latency_of(3, 2), 0, 1'b0);
    check_image("after_abort", 18);

`ifdef BMP_HDR_CHECK_EN
    // bad pixel depth is rejected without pixel access
    prep_image(2, 2, 54, 32);
    load_image();
    exp_img = img;
    run_conv("bpp32", 31, 0, 1'b1);
    check_image("bpp32", 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
